// File: rtl/wb_arb_pkg.sv
// Shared defaults and state encoding for the Wishbone round-robin arbiter.
package wb_arb_pkg;

   localparam int NM_DEF      = 4;
   localparam int AW_DEF      = 8;
   localparam int DW_DEF      = 8;
   localparam int SW_DEF      = 1;
   localparam int TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      TOUT = 2'b10
   } arb_state_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the per-master request lanes, the shared slave port and the grant vector.
interface wb_arbiter_if
   import wb_arb_pkg::*;
#(
   parameter int NM = NM_DEF,
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF,
   parameter int SW = SW_DEF
);
   logic [NM-1:0]    M_CYC_I;
   logic [NM-1:0]    M_STB_I;
   logic [NM-1:0]    M_WE_I;
   logic [NM*AW-1:0] M_ADR_I;
   logic [NM*DW-1:0] M_DAT_I;
   logic [NM*SW-1:0] M_SEL_I;
   logic [NM-1:0]    M_ACK_O;
   logic [NM-1:0]    M_ERR_O;
   logic [DW-1:0]    M_DAT_O;

   logic             S_CYC_O;
   logic             S_STB_O;
   logic             S_WE_O;
   logic [AW-1:0]    S_ADR_O;
   logic [DW-1:0]    S_DAT_O;
   logic [SW-1:0]    S_SEL_O;
   logic [DW-1:0]    S_DAT_I;
   logic             S_ACK_I;
   logic             S_ERR_I;

   logic [NM-1:0]    GNT_O;

   // Arbiter view: takes master requests and slave responses, drives the rest.
   modport slave (
      input  M_CYC_I, M_STB_I, M_WE_I, M_ADR_I, M_DAT_I, M_SEL_I,
      input  S_DAT_I, S_ACK_I, S_ERR_I,
      output M_ACK_O, M_ERR_O, M_DAT_O,
      output S_CYC_O, S_STB_O, S_WE_O, S_ADR_O, S_DAT_O, S_SEL_O,
      output GNT_O
   );

   // Environment view: the masters and the slave attached around the arbiter.
   modport master (
      output M_CYC_I, M_STB_I, M_WE_I, M_ADR_I, M_DAT_I, M_SEL_I,
      output S_DAT_I, S_ACK_I, S_ERR_I,
      input  M_ACK_O, M_ERR_O, M_DAT_O,
      input  S_CYC_O, S_STB_O, S_WE_O, S_ADR_O, S_DAT_O, S_SEL_O,
      input  GNT_O
   );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after last_gnt, one-hot.
module wb_rr_pick
   import wb_arb_pkg::*;
#(
   parameter int NM = NM_DEF,
   localparam int IW = (NM > 1) ? $clog2(NM) : 1
) (
   input  logic [NM-1:0] req,
   input  logic [IW-1:0] last_gnt,
   output logic [NM-1:0] pick
);

   logic          found;
   logic [IW-1:0] idx;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      // Scan last_gnt+1 .. last_gnt+NM so the previous owner is checked last.
      for (int i = 1; i <= NM; i++) begin
         idx = IW'((int'(last_gnt) + i) % NM);
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Non-preemptive round-robin Wishbone arbiter, NM masters onto one slave.
// Define WB_ARB_TIMEOUT_EN to add the stalled-slave watchdog and TOUT state.
module wb_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NM      = NM_DEF,
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int SW      = SW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic         CLK_I,
   input  logic         RST_I,
   wb_arbiter_if.slave  bus
);

   localparam int IW = (NM > 1) ? $clog2(NM) : 1;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("wb_arbiter: TIMEOUT must be at least 1");
   end

   arb_state_t    state, state_nxt;
   logic [NM-1:0] gnt, pick;
   logic [IW-1:0] gnt_idx, pick_idx, last_gnt;
   logic [NM-1:0] m_ack, m_err;
   logic          wd_fire;

   wb_rr_pick #(.NM(NM)) u_pick (
      .req      (bus.M_CYC_I),
      .last_gnt (last_gnt),
      .pick     (pick)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NM; i++)
         if (pick[i]) pick_idx = IW'(i);
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wd_cnt;
   logic          stall;

   assign stall   = (state == BUSY) && bus.M_STB_I[gnt_idx] && !bus.S_ACK_I && !bus.S_ERR_I;
   assign wd_fire = stall && (wd_cnt == CW'(TIMEOUT - 1));

   // Leaving BUSY (or a fresh grant) restarts the count from zero.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I)                                           wd_cnt <= '0;
      else if (state != BUSY || bus.S_ACK_I || bus.S_ERR_I) wd_cnt <= '0;
      else if (stall)                                      wd_cnt <= wd_cnt + 1'b1;
   end
`else
   assign wd_fire = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|bus.M_CYC_I) state_nxt = BUSY;
         BUSY:    if (!bus.M_CYC_I[gnt_idx]) state_nxt = IDLE;
                  else if (wd_fire)         state_nxt = TOUT;
         TOUT:    if (!bus.M_CYC_I[gnt_idx]) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state    <= IDLE;
         gnt      <= '0;
         gnt_idx  <= '0;
         last_gnt <= IW'(NM - 1);
      end else begin
         state <= state_nxt;
         if (state == IDLE && state_nxt == BUSY) begin
            gnt     <= pick;
            gnt_idx <= pick_idx;
         end else if (state != IDLE && state_nxt == IDLE) begin
            gnt      <= '0;
            last_gnt <= gnt_idx;
         end
      end
   end

   // Slave side is only connected while BUSY; a watchdog hit cuts it off that same cycle.
   always_comb begin
      bus.S_CYC_O = 1'b0;
      bus.S_STB_O = 1'b0;
      bus.S_WE_O  = 1'b0;
      bus.S_ADR_O = '0;
      bus.S_DAT_O = '0;
      bus.S_SEL_O = '0;
      m_ack       = '0;
      m_err       = '0;
      if (state == BUSY) begin
         if (wd_fire) begin
            m_err[gnt_idx] = 1'b1;
         end else begin
            bus.S_CYC_O    = bus.M_CYC_I[gnt_idx];
            bus.S_STB_O    = bus.M_STB_I[gnt_idx];
            bus.S_WE_O     = bus.M_WE_I[gnt_idx];
            bus.S_ADR_O    = bus.M_ADR_I[gnt_idx*AW +: AW];
            bus.S_DAT_O    = bus.M_DAT_I[gnt_idx*DW +: DW];
            bus.S_SEL_O    = bus.M_SEL_I[gnt_idx*SW +: SW];
            m_ack[gnt_idx] = bus.S_ACK_I & ~bus.S_ERR_I;
            m_err[gnt_idx] = bus.S_ERR_I;
         end
      end
   end

   assign bus.M_ACK_O = m_ack;
   assign bus.M_ERR_O = m_err;
   assign bus.M_DAT_O = bus.S_DAT_I;
   assign bus.GNT_O   = gnt;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NM, default 4, giving the number of Wishbone masters sharing one slave port.
REQ-002 SHALL have parameter AW, default 8, giving the address width.
REQ-003 SHALL have parameter DW, default 8, giving the data width.
REQ-004 SHALL have parameter SW, default 1, giving the select width.
REQ-005 SHALL have parameter TIMEOUT, default 16, giving the watchdog limit in cycles.
REQ-006 SHALL have port CLK_I  in  1  sole clock.
REQ-007 SHALL have port RST_I  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports M_CYC_I / M_STB_I / M_WE_I  in  NM each  per-master cycle, strobe and write-enable.
REQ-009 SHALL have ports M_ADR_I  in  NM*AW, M_DAT_I  in  NM*DW and M_SEL_I  in  NM*SW, packed per master with master 0 in the LSBs.
REQ-010 SHALL have ports M_ACK_O / M_ERR_O  out  NM each  per-master acknowledge and error.
REQ-011 SHALL have port M_DAT_O  out  DW  read data, broadcast to all masters.
REQ-012 SHALL have ports S_CYC_O / S_STB_O / S_WE_O  out  1, S_ADR_O  out  AW, S_DAT_O  out  DW and S_SEL_O  out  SW  to the slave.
REQ-013 SHALL have ports S_DAT_I  in  DW, S_ACK_I  in  1 and S_ERR_I  in  1  from the slave.
REQ-014 SHALL have port GNT_O  out  NM  one-hot registered grant, all zero when no master owns the bus.

Function
REQ-015 SHALL implement the states IDLE and BUSY, plus TOUT when WB_ARB_TIMEOUT_EN is defined.
REQ-016 In IDLE with any M_CYC_I high, SHALL select the first requester in round-robin order starting at last_gnt+1 (mod NM), register GNT_O, and enter BUSY on the next edge; grant latency is 1 cycle.
REQ-017 In IDLE, SHALL drive S_CYC_O, S_STB_O, S_WE_O, S_ADR_O, S_DAT_O and S_SEL_O to 0, and all M_ACK_O and M_ERR_O to 0.
REQ-018 In BUSY, SHALL combinationally pass the granted master's CYC, STB, WE, ADR, DAT and SEL to the S_* outputs.
REQ-019 In BUSY, SHALL route S_ACK_I and S_ERR_I only to the granted master's M_ACK_O/M_ERR_O bit and hold every other bit at 0.
REQ-020 SHALL drive M_DAT_O = S_DAT_I at all times.
REQ-021 SHALL NOT preempt: the grant is held for multi-beat cycles until the granted M_CYC_I falls.
REQ-022 When the granted M_CYC_I falls, SHALL return to IDLE, set last_gnt to the granted index and clear GNT_O, leaving exactly one idle cycle between grants.
REQ-023 When S_ACK_I and S_ERR_I are high in the same cycle, SHALL deliver ERR and suppress ACK.
REQ-024 SHALL ignore requests from non-granted masters in BUSY; they wait with no ACK or ERR.
REQ-025 With a single requester, SHALL regrant it after the idle cycle.

Reset
REQ-026 RST_I high SHALL force IDLE, GNT_O=0, last_gnt=NM-1 (so master 0 has first priority) and the watchdog counter to 0, with all outputs as in REQ-017.
REQ-027 Reset asserted during BUSY SHALL abort the cycle immediately (S_CYC_O low asynchronously) without issuing ACK or ERR.

Configuration
REQ-028 With macro WB_ARB_TIMEOUT_EN defined, a counter SHALL increment each BUSY cycle where S_STB_O is high and neither S_ACK_I nor S_ERR_I is high, and clear on ACK, ERR or grant.
REQ-029 With WB_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT the block SHALL pulse M_ERR_O[g] for one cycle, drive S_CYC_O/S_STB_O to 0, enter TOUT, and go to IDLE when M_CYC_I[g] falls.
REQ-030 Without WB_ARB_TIMEOUT_EN, SHALL have no counter and no TOUT state, and SHALL wait indefinitely for the slave.

Structure
REQ-031 Package wb_arb_pkg SHALL hold the AW/DW/SW/NM/TIMEOUT defaults and the state encoding (IDLE=2'b00, BUSY=2'b01, TOUT=2'b10).
REQ-032 The combinational round-robin picker SHALL be sub-module wb_rr_pick (inputs: request vector, last_gnt; output: one-hot pick).

Verification
REQ-033 After reset, M_CYC_I=4'b1111 -> GNT_O=4'b0001 one cycle later; successive 1-beat transfers with all masters requesting -> grants rotate 0001, 0010, 0100, 1000, 0001.
REQ-034 Master 2 writes ADR=8'hFF, DAT=8'h5A, slave ACKs on its 2nd STB cycle -> S_ADR_O=8'hFF, S_DAT_O=8'h5A, M_ACK_O=4'b0100 for exactly 1 cycle.
REQ-035 Master 1 holds CYC for 3 beats while master 3 requests -> GNT_O stays 4'b0010 throughout; 4'b1000 follows after one idle cycle.
REQ-036 Slave raises ACK and ERR together for master 0 -> M_ERR_O=4'b0001 and M_ACK_O=0.
REQ-037 With WB_ARB_TIMEOUT_EN and TIMEOUT=16, slave never ACKs -> M_ERR_O[g] pulses on the 16th stalled cycle and S_CYC_O=0 the same cycle; without the macro the bus remains held.
REQ-038 RST_I asserted mid-BUSY -> S_CYC_O=0 and GNT_O=0 immediately, no ACK/ERR, and master 0 wins the next arbitration.
